regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file with write-through bypass and a busy-bit scoreboard.
//  Successor to the single-write, dual-read file. Sits between decode (read, issue) and writeback in the RV32IM pipeline.
//  Reads are combinational and see same-cycle writes. Register 0 is hardwired to zero.
//  Scoreboard tracks registers with an in-flight producer so decode can stall without a separate hazard unit.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  architectural register count (power of 2, >=2)
//  NRD      2   number of read ports
//  NWR      1   number of write ports (1..2)
//  AW       $clog2(NREGS)  address width (derived, localparam)
// PORTS
//  clk_i        in   1         single clock, all state updates on posedge
//  rst_i        in   1         synchronous, active-high reset
//  rd_addr_i    in   NRD*AW    read addresses, port k at [k*AW +: AW]
//  rd_data_o    out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//  rd_busy_o    out  NRD       port k's register has a pending producer
//  wr_en_i      in   NWR       write enables
//  wr_addr_i    in   NWR*AW    write addresses
//  wr_data_i    in   NWR*XLEN  write data
//  iss_en_i     in   1         decode issues an instruction that will write iss_addr_i
//  iss_addr_i   in   AW        destination of issued instruction
//  flush_i      in   1         pipeline flush: clear all busy bits
//  stall_o      out  1         OR over k of rd_busy_o[k] (unmasked; decode masks unused ports)
// BEHAVIOUR
//  Reset: on posedge with rst_i=1, all registers <= 0 and all busy bits <= 0; rst_i overrides every other input.
//  Outputs during reset are combinational from the cleared state.
//  Write: on posedge, for each j with wr_en_i[j]=1 and wr_addr_i[j]!=0, reg[wr_addr_i[j]] <= wr_data_i[j].
//  Writes to address 0 are dropped.
//  Two ports writing the same address in one cycle: the higher port index wins.
//  Read: zero-latency combinational read. rd_data_o[k]=0 when the address is 0.
//  Otherwise, if any enabled write port targets that address this cycle, rd_data_o[k] returns that port's data
//  (highest index wins). Else it returns the stored value.
//  Scoreboard: busy[NREGS-1:1] register, busy[0] constant 0. Next-state order of precedence:
//   1. flush_i=1: all busy <= 0, including any same-cycle issue.
//   2. Any enabled write to address a clears busy[a].
//   3. iss_en_i=1 with iss_addr_i!=0 sets busy[iss_addr_i]. Set beats a same-cycle clear of the same address
//      (a new producer supersedes an old one).
//  rd_busy_o[k] = busy[rd_addr_i[k]] & ~(write to rd_addr_i[k] this cycle); the bypass resolves the hazard.
//  iss_en_i with iss_addr_i=0 has no effect.
//  Writes do not require a prior issue: an un-scoreboarded write just updates data.
//  No X propagation: unused ports with address 0 read 0 and report busy 0.
// STRUCTURE
//  Package rf_pkg: XLEN, NREGS, AW defaults, typedef reg_addr_t [AW-1:0] and reg_data_t [XLEN-1:0],
//  and constant ZERO_REG = 0.
//  Sub-module regfile_scoreboard (busy vector, set/clear/flush precedence, per-port busy lookup with write mask).
//  Data array, bypass muxing and write-priority logic stay in the top module, using generate loops over NRD/NWR.
// TESTING
//  1. Reset: write x5=0xDEADBEEF, then assert rst_i for 1 cycle -> read x5 = 0, all rd_busy_o = 0, stall_o = 0.
//  2. Same-cycle write/read: wr x7=0x12345678 while rd_addr_i[0]=7 -> rd_data_o[0]=0x12345678 that cycle;
//     after the edge the stored value reads the same.
//  3. x0: write x0=0xFFFFFFFF, then read x0 -> 0. Issue to x0 -> rd_busy_o stays 0.
//  4. Scoreboard: issue x3 -> next cycle read x3 gives rd_busy_o=1, stall_o=1.
//     Write x3=0xA5 -> that cycle rd_busy_o=0 and data=0xA5; next cycle busy=0.
//  5. Precedence: busy x4 set. Same cycle: write x4 and issue x4 -> x4 remains busy.
//     Then issue x9 with flush_i=1 -> all busy 0.
//  6. NWR=2: both ports write x10 (0x1 on port 0, 0x2 on port 1) -> bypass and stored value both = 0x2.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, address/data types and constants for the multi-port register file.
// The typedefs describe the default RV32 configuration; parametrised instances size their own vectors.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int ZERO_REG = 0;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register that has an in-flight producer.
// A bit is set on issue and cleared by writeback; flush clears every bit.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = rf_pkg::NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    input  logic              flush_i,
    output logic [NRD-1:0]    rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Precedence, lowest to highest: writeback clear, issue set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_addr_i != AW'(ZERO_REG))) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A same-cycle write to the looked-up register resolves the hazard through the bypass.
    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        logic [AW-1:0] addr;
        logic          wr_hit;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            wr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr)) begin
                    wr_hit = 1'b1;
                end
            end
        end

        assign rd_busy_o[k] = busy_q[addr] & ~wr_hit;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass and busy-bit scoreboard.
// x0 reads as zero; when two write ports hit the same register the higher index wins.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int NREGS = rf_pkg::NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NRD*$clog2(NREGS)-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0]            rd_data_o,
    output logic [NRD-1:0]                 rd_busy_o,
    input  logic [NWR-1:0]                 wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0]            wr_data_i,
    input  logic                           iss_en_i,
    input  logic [$clog2(NREGS)-1:0]       iss_addr_i,
    input  logic                           flush_i,
    output logic                           stall_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [NWR-1:0]  wr_live;

    // A write is live only when enabled and not aimed at x0.
    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wr_live[j] = wr_en_i[j] && (wr_addr_i[j*AW +: AW] != AW'(ZERO_REG));
    end

    // Ascending loop order makes the highest-index port's update the surviving one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_live[j]) begin
                    mem_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            data = mem_q[addr];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr)) begin
                    data = wr_data_i[j*XLEN +: XLEN];
                end
            end
            if (addr == AW'(ZERO_REG)) begin
                data = '0;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = data;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_addr_i  (rd_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .rd_busy_o  (rd_busy_o)
    );

    // Unmasked: decode ignores stalls caused by read ports it does not use.
    assign stall_o = |rd_busy_o;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and randomized checks of regfile_mp_sb (2 read, 2 write ports) against a
// register-array/busy-array reference model.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NRD*AW-1:0]    rd_addr_i;
    logic [NRD*XLEN-1:0]  rd_data_o;
    logic [NRD-1:0]       rd_busy_o;
    logic [NWR-1:0]       wr_en_i;
    logic [NWR*AW-1:0]    wr_addr_i;
    logic [NWR*XLEN-1:0]  wr_data_i;
    logic                 iss_en_i;
    logic [AW-1:0]        iss_addr_i;
    logic                 flush_i;
    logic                 stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] ref_regs [NREGS];
    bit              ref_busy [NREGS];

    always #5 clk_i = ~clk_i;

    regfile_mp_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int k, input int addr);
        rd_addr_i[k*AW +: AW] = AW'(addr);
    endtask

    task automatic set_wr(input int j, input bit en, input int addr, input logic [XLEN-1:0] data);
        wr_en_i[j]                 = en;
        wr_addr_i[j*AW +: AW]      = AW'(addr);
        wr_data_i[j*XLEN +: XLEN]  = data;
    endtask

    task automatic set_iss(input bit en, input int addr);
        iss_en_i   = en;
        iss_addr_i = AW'(addr);
    endtask

    // Clears control inputs; read addresses are left as they are.
    task automatic clear_ctl();
        rst_i   = 1'b0;
        flush_i = 1'b0;
        set_iss(1'b0, 0);
        for (int j = 0; j < NWR; j++) set_wr(j, 1'b0, 0, '0);
    endtask

    function automatic int rd_addr(input int k);
        return int'(rd_addr_i[k*AW +: AW]);
    endfunction

    function automatic bit write_hits(input int addr);
        for (int j = 0; j < NWR; j++)
            if (wr_en_i[j] && int'(wr_addr_i[j*AW +: AW]) == addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int addr);
        logic [XLEN-1:0] v;
        if (addr == 0) return '0;
        v = ref_regs[addr];
        for (int j = 0; j < NWR; j++)
            if (wr_en_i[j] && int'(wr_addr_i[j*AW +: AW]) == addr) v = wr_data_i[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input int addr);
        return ref_busy[addr] && !write_hits(addr);
    endfunction

    task automatic check_model(input string tag);
        bit any_busy = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("%s_data%0d", tag, k), rd_data_o[k*XLEN +: XLEN], exp_data(rd_addr(k)));
            chk($sformatf("%s_busy%0d", tag, k), XLEN'(rd_busy_o[k]), XLEN'(exp_busy(rd_addr(k))));
            any_busy |= exp_busy(rd_addr(k));
        end
        chk($sformatf("%s_stall", tag), XLEN'(stall_o), XLEN'(any_busy));
    endtask

    // Architectural effect of the current inputs at the coming clock edge.
    task automatic model_update();
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                ref_regs[i] = '0;
                ref_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j]) begin
                    if (wr_addr_i[j*AW +: AW] != 0)
                        ref_regs[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
                    ref_busy[wr_addr_i[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en_i && iss_addr_i != 0) ref_busy[iss_addr_i] = 1'b1;
            if (flush_i) for (int i = 0; i < NREGS; i++) ref_busy[i] = 1'b0;
        end
    endtask

    task automatic tick(input string tag);
        #1;
        check_model(tag);
        model_update();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rd_addr_i = '0;
        clear_ctl();
        rst_i = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            ref_regs[i] = '0;
            ref_busy[i] = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        clear_ctl();

        // Reset clears data and busy bits
        set_wr(0, 1'b1, 5, 32'hDEADBEEF);
        set_iss(1'b1, 6);
        set_rd(0, 5);
        set_rd(1, 6);
        tick("rst_pre");
        clear_ctl();
        #1;
        chk("pre_rst_x5", rd_data_o[31:0], 32'hDEADBEEF);
        chk("pre_rst_busy6", XLEN'(rd_busy_o[1]), 32'd1);
        rst_i = 1'b1;
        tick("rst_cyc");
        clear_ctl();
        #1;
        chk("rst_x5", rd_data_o[31:0], 32'h0);
        chk("rst_busy", XLEN'(rd_busy_o), 32'h0);
        chk("rst_stall", XLEN'(stall_o), 32'h0);

        // Same-cycle write/read bypass
        set_wr(0, 1'b1, 7, 32'h12345678);
        set_rd(0, 7);
        #1;
        chk("byp_x7", rd_data_o[31:0], 32'h12345678);
        tick("byp");
        clear_ctl();
        #1;
        chk("stored_x7", rd_data_o[31:0], 32'h12345678);

        // x0 hardwired
        set_wr(0, 1'b1, 0, 32'hFFFFFFFF);
        set_iss(1'b1, 0);
        set_rd(0, 0);
        #1;
        chk("x0_byp", rd_data_o[31:0], 32'h0);
        tick("x0");
        clear_ctl();
        #1;
        chk("x0_data", rd_data_o[31:0], 32'h0);
        chk("x0_busy", XLEN'(rd_busy_o[0]), 32'h0);

        // Issue then writeback
        set_iss(1'b1, 3);
        tick("iss3");
        clear_ctl();
        set_rd(0, 3);
        #1;
        chk("x3_busy", XLEN'(rd_busy_o[0]), 32'd1);
        chk("x3_stall", XLEN'(stall_o), 32'd1);
        set_wr(0, 1'b1, 3, 32'hA5);
        #1;
        chk("x3_wb_busy", XLEN'(rd_busy_o[0]), 32'd0);
        chk("x3_wb_data", rd_data_o[31:0], 32'hA5);
        tick("wb3");
        clear_ctl();
        #1;
        chk("x3_after_busy", XLEN'(rd_busy_o[0]), 32'd0);

        // Set beats clear; flush beats set
        set_iss(1'b1, 4);
        tick("iss4");
        clear_ctl();
        set_rd(0, 4);
        set_wr(0, 1'b1, 4, 32'h55);
        set_iss(1'b1, 4);
        tick("wb_iss4");
        clear_ctl();
        #1;
        chk("x4_still_busy", XLEN'(rd_busy_o[0]), 32'd1);
        set_iss(1'b1, 9);
        flush_i = 1'b1;
        set_rd(1, 9);
        tick("flush");
        clear_ctl();
        #1;
        chk("flush_busy", XLEN'(rd_busy_o), 32'h0);
        chk("flush_stall", XLEN'(stall_o), 32'h0);

        // Dual write to one register: higher port wins
        set_wr(0, 1'b1, 10, 32'h1);
        set_wr(1, 1'b1, 10, 32'h2);
        set_rd(0, 10);
        #1;
        chk("dual_byp", rd_data_o[31:0], 32'h2);
        tick("dual");
        clear_ctl();
        #1;
        chk("dual_stored", rd_data_o[31:0], 32'h2);

        // Randomized traffic over a narrow address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
            rst_i   = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            set_iss($urandom_range(0, 1), $urandom_range(0, hi));
            for (int j = 0; j < NWR; j++)
                set_wr(j, $urandom_range(0, 2) == 0, $urandom_range(0, hi), $urandom());
            for (int k = 0; k < NRD; k++)
                set_rd(k, $urandom_range(0, hi));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
